// File: rtl/cs_strobe_seq.sv
// Decoder chip-select strobe sequencer: queues device requests in a 2-entry FIFO and
// plays each one out as SETUP / STROBE (dec_g low) / HOLD on a 2-to-4 decoder interface.
module cs_strobe_seq #(
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_dev,
    output logic       req_ready,
    output logic       dec_g,
    output logic       dec_a,
    output logic       dec_b,
    output logic       busy,
    output logic       done,
    output logic [1:0] done_dev,
    output logic [1:0] dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready depends only on the registered FIFO count, never on req_valid.

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [3:0] LP_S_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] LP_H_LAST = 4'(HOLD_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_mem [2];
    logic       r_wr_ptr, r_rd_ptr;
    logic [1:0] r_count;
    logic [1:0] r_sel, w_sel_nxt;
    logic       r_dec_g, r_busy, r_done;
    logic [1:0] r_done_dev;
    logic       w_push, w_pop, w_done_nxt;
    logic [1:0] w_head;

    assign req_ready = ~r_count[1];
    assign w_push    = req_valid && req_ready;
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != 2'd0) begin
                    w_pop       = 1'b1;
                    w_sel_nxt   = w_head;
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = 4'd0;
                end
            end
            SETUP: begin
                w_state_nxt = STROBE;
                w_cnt_nxt   = 4'd0;
            end
            STROBE: begin
                if (r_cnt == LP_S_LAST) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            HOLD: begin
                // Chain straight into the next SETUP so back-to-back accesses skip IDLE.
                if (r_cnt == LP_H_LAST) begin
                    w_cnt_nxt = 4'd0;
                    if (r_count != 2'd0) begin
                        w_pop       = 1'b1;
                        w_sel_nxt   = w_head;
                        w_state_nxt = SETUP;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
        w_done_nxt = (w_state_nxt == HOLD) && (w_cnt_nxt == LP_H_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_sel      <= 2'd0;
            r_dec_g    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_done_dev <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sel      <= w_sel_nxt;
            r_dec_g    <= (w_state_nxt != STROBE);
            r_busy     <= (w_state_nxt != IDLE);
            r_done     <= w_done_nxt;
            r_done_dev <= w_done_nxt ? w_sel_nxt : r_done_dev;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= 2'd0;
            r_mem[1] <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= req_dev;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign dec_g     = r_dec_g;
    assign dec_a     = r_sel[0];
    assign dec_b     = r_sel[1];
    assign busy      = r_busy;
    assign done      = r_done;
    assign done_dev  = r_done_dev;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cs_strobe_seq.sv
// Bench for cs_strobe_seq: unit 0 uses default timing, unit 1 uses STROBE=1/HOLD=3.
module tb_cs_strobe_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_v = 2'b00;
    logic [3:0] req_d = 4'd0;
    logic [1:0] req_rdy, dec_g, dec_a, dec_b, busy, done;
    logic [3:0] done_dev_w, dbg_w;
    logic       final_req = 1'b0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    cs_strobe_seq u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_v[0]), .req_dev(req_d[1:0]),
        .req_ready(req_rdy[0]), .dec_g(dec_g[0]), .dec_a(dec_a[0]), .dec_b(dec_b[0]),
        .busy(busy[0]), .done(done[0]), .done_dev(done_dev_w[1:0]), .dbg_state(dbg_w[1:0])
    );

    cs_strobe_seq #(.STROBE_CYCLES(1), .HOLD_CYCLES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_v[1]), .req_dev(req_d[3:2]),
        .req_ready(req_rdy[1]), .dec_g(dec_g[1]), .dec_a(dec_a[1]), .dec_b(dec_b[1]),
        .busy(busy[1]), .done(done[1]), .done_dev(done_dev_w[3:2]), .dbg_state(dbg_w[3:2])
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Call at posedge+#1; returns at posedge+#1 of the cycle after acceptance.
    task automatic send(input int u, input logic [1:0] dev);
        int n = 0;
        bit ok = 0;
        req_v[u] = 1'b1;
        req_d[u*2 +: 2] = dev;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (req_rdy[u]) ok = 1;
            @(posedge clk);
            #1;
            n++;
        end
        req_v[u] = 1'b0;
        chk("send_accept", int'(ok), 1);
    endtask

    // Per-unit scoreboard: accepted devices are expected at strobe start and at done.
    for (genvar u = 0; u < 2; u++) begin : g_mon
        localparam int S = (u == 0) ? 2 : 1;
        localparam int H = (u == 0) ? 1 : 3;
        logic [1:0] exp_q[$];
        logic [1:0] done_q[$];
        logic [1:0] sel, prev_sel = 2'd0;
        logic       prev_g = 1'b1, in_hold = 1'b0, fin = 1'b0;
        int         lo_cnt = 0, hi_cnt = 0;

        always @(negedge clk) begin
            sel = {dec_b[u], dec_a[u]};
            if (!rst_n) begin
                exp_q.delete();
                done_q.delete();
                prev_g  = 1'b1;
                in_hold = 1'b0;
                prev_sel = sel;
            end else begin
                if (req_v[u] && req_rdy[u]) begin
                    exp_q.push_back(req_d[u*2 +: 2]);
                    done_q.push_back(req_d[u*2 +: 2]);
                end
                if (!prev_g || in_hold) chk($sformatf("sel_stable%0d", u), int'(sel), int'(prev_sel));
                if (!dec_g[u]) begin
                    if (prev_g) begin
                        chk($sformatf("strobe_expected%0d", u), int'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) chk($sformatf("strobe_sel%0d", u), int'(sel), int'(exp_q.pop_front()));
                        lo_cnt = 0;
                    end
                    lo_cnt++;
                    in_hold = 1'b0;
                end else if (!prev_g) begin
                    chk($sformatf("strobe_len%0d", u), lo_cnt, S);
                    in_hold = 1'b1;
                    hi_cnt  = 0;
                end
                if (dec_g[u] && in_hold) hi_cnt++;
                if (done[u]) begin
                    chk($sformatf("done_in_last_hold%0d", u), int'(in_hold && hi_cnt == H), 1);
                    chk($sformatf("done_expected%0d", u), int'(done_q.size() != 0), 1);
                    if (done_q.size() != 0) chk($sformatf("done_dev%0d", u), int'(done_dev_w[u*2 +: 2]), int'(done_q.pop_front()));
                    in_hold = 1'b0;
                end
                if (final_req && !fin) begin
                    chk($sformatf("strobe_q_drained%0d", u), exp_q.size(), 0);
                    chk($sformatf("done_q_drained%0d", u), done_q.size(), 0);
                    fin = 1'b1;
                end
                prev_g   = dec_g[u];
                prev_sel = sel;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        for (int u = 0; u < 2; u++) begin
            chk({tag, "_dec_g"}, int'(dec_g[u]), 1);
            chk({tag, "_sel"}, int'({dec_b[u], dec_a[u]}), 0);
            chk({tag, "_busy"}, int'(busy[u]), 0);
            chk({tag, "_done"}, int'(done[u]), 0);
            chk({tag, "_done_dev"}, int'(done_dev_w[u*2 +: 2]), 0);
            chk({tag, "_ready"}, int'(req_rdy[u]), 1);
            chk({tag, "_state"}, int'(dbg_w[u*2 +: 2]), 0);
        end
    endtask

    initial begin
        int dc0[$], dc1[$];
        int n;

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Single request dev=2 accepted in cycle 0 on both units; exact cycle profile.
        @(posedge clk); #1;
        req_v = 2'b11;
        req_d = {2'd2, 2'd2};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("t0_g_c%0d", c), int'(dec_g[0]), int'(!(c == 3 || c == 4)));
            chk($sformatf("t0_busy_c%0d", c), int'(busy[0]), int'(c >= 2 && c <= 5));
            chk($sformatf("t0_done_c%0d", c), int'(done[0]), int'(c == 5));
            chk($sformatf("t1_g_c%0d", c), int'(dec_g[1]), int'(c != 3));
            chk($sformatf("t1_busy_c%0d", c), int'(busy[1]), int'(c >= 2 && c <= 6));
            chk($sformatf("t1_done_c%0d", c), int'(done[1]), int'(c == 6));
            if (c >= 2 && c <= 5) chk($sformatf("t0_sel_c%0d", c), int'({dec_b[0], dec_a[0]}), 2);
            if (c >= 2 && c <= 6) chk($sformatf("t1_sel_c%0d", c), int'({dec_b[1], dec_a[1]}), 2);
            if (c == 0) begin
                @(posedge clk); #1;
                req_v = 2'b00;
            end
        end

        // Back-to-back backlog: 0,1,3 fill the FIFO, 2 is held while not ready.
        @(posedge clk); #1;
        fork
            begin
                send(0, 2'd0); send(0, 2'd1); send(0, 2'd3);
                chk("full_ready0", int'(req_rdy[0]), 0);
                send(0, 2'd2);
            end
            begin
                send(1, 2'd0); send(1, 2'd1); send(1, 2'd3);
                chk("full_ready1", int'(req_rdy[1]), 0);
                send(1, 2'd2);
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (done[0]) dc0.push_back(c);
                    if (done[1]) dc1.push_back(c);
                end
            end
        join
        chk("b2b_count0", dc0.size(), 4);
        chk("b2b_count1", dc1.size(), 4);
        for (int i = 1; i < dc0.size(); i++) chk("b2b_gap0", dc0[i] - dc0[i-1], 4);
        for (int i = 1; i < dc1.size(); i++) chk("b2b_gap1", dc1[i] - dc1[i-1], 5);

        // Random traffic with random gaps on both units.
        fork
            for (int k = 0; k < 25; k++) begin
                send(0, 2'($urandom_range(0, 3)));
                repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
            end
            for (int k = 0; k < 25; k++) begin
                send(1, 2'($urandom_range(0, 3)));
                repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
            end
        join
        n = 0;
        do begin
            repeat (4) @(negedge clk);
            n++;
        end while (busy != 2'b00 && n < 100);
        chk("drain_idle", int'(busy), 0);

        // Reset during unit 0's strobe with one request still queued.
        @(posedge clk); #1;
        send(0, 2'd1);
        send(0, 2'd3);
        n = 0;
        while (dec_g[0] && n < 20) begin @(negedge clk); n++; end
        chk("reach_strobe", int'(dec_g[0]), 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("post_rst_busy0", int'(busy[0]), 0);
            chk("post_rst_g0", int'(dec_g[0]), 1);
            chk("post_rst_ready0", int'(req_rdy[0]), 1);
        end

        // First access after release keeps the nominal latency.
        @(posedge clk); #1;
        req_v[0] = 1'b1;
        req_d[1:0] = 2'd3;
        @(posedge clk); #1;
        req_v[0] = 1'b0;
        @(negedge clk);
        chk("lat_c1_busy", int'(busy[0]), 0);
        @(negedge clk);
        chk("lat_c2_busy", int'(busy[0]), 1);
        chk("lat_c2_g", int'(dec_g[0]), 1);
        @(negedge clk);
        chk("lat_c3_g", int'(dec_g[0]), 0);
        repeat (5) @(negedge clk);

        final_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
